// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - shared state, opcode and instruction-class definitions
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    STATE_IF     = 3'd0,
    STATE_ID     = 3'd1,
    STATE_EX     = 3'd2,
    STATE_MEM    = 3'd3,
    STATE_WB     = 3'd4,
    STATE_OUTPUT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_LW      = 3'd1,
    CLS_SW      = 3'd2,
    CLS_BR      = 3'd3,
    CLS_J       = 3'd4,
    CLS_ILLEGAL = 3'd5
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/multicycle_sequencer_instr_class_decode.sv
// rtl/multicycle_sequencer_instr_class_decode.sv - combinational opcode to instruction-class decode
module instr_class_decode
  import multicycle_sequencer_pkg::*;
(
  input  logic [5:0] opcode,
  output cls_t       cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_RTYPE:       cls = CLS_RTYPE;
      OP_LW:          cls = CLS_LW;
      OP_SW:          cls = CLS_SW;
      OP_BEQ, OP_BNE: cls = CLS_BR;
      OP_J:           cls = CLS_J;
      default:        cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle MIPS control-state sequencer
// Optional performance counters: MULTICYCLE_SEQ_PERF_EN
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int PROG_END = 11,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  pc,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [PC_W-1:0] PROG_END_PC = PC_W'(PROG_END);

  state_t state_q, state_d;
  cls_t   class_q, cls_id;
  logic   illegal_q, set_illegal, final_stage;

  instr_class_decode u_decode (
    .opcode (opcode),
    .cls    (cls_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STATE_IF;
      class_q   <= CLS_RTYPE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == STATE_ID) class_q <= cls_id;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    final_stage = 1'b0;
    instr_done  = 1'b0;
    case (state_q)
      STATE_IF: if (mem_ready) state_d = STATE_ID;
      STATE_ID: begin
        if (cls_id == CLS_ILLEGAL) begin
          state_d     = STATE_OUTPUT;
          set_illegal = 1'b1;
        end else if (cls_id == CLS_J) begin
          final_stage = 1'b1;
        end else begin
          state_d = STATE_EX;
        end
      end
      STATE_EX: begin
        if (class_q == CLS_BR)                           final_stage = 1'b1;
        else if (class_q == CLS_LW || class_q == CLS_SW) state_d = STATE_MEM;
        else                                             state_d = STATE_WB;
      end
      STATE_MEM: begin
        if (mem_ready) begin
          if (class_q == CLS_LW) state_d = STATE_WB;
          else                   final_stage = 1'b1;
        end
      end
      STATE_WB:     final_stage = 1'b1;
      STATE_OUTPUT: state_d = STATE_OUTPUT;
      default:      state_d = STATE_OUTPUT;
    endcase
    // The instruction retires here; pc decides whether another one follows.
    if (final_stage) begin
      instr_done = 1'b1;
      state_d    = (pc < PROG_END_PC) ? STATE_IF : STATE_OUTPUT;
    end
  end

  assign state      = state_q;
  assign halted     = (state_q == STATE_OUTPUT);
  assign illegal_op = illegal_q;

`ifdef MULTICYCLE_SEQ_PERF_EN
  logic [CNT_W-1:0] cycle_q, instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (state_q != STATE_OUTPUT && cycle_q != '1) cycle_q <= cycle_q + 1'b1;
      if (instr_done && instr_q != '1)              instr_q <= instr_q + 1'b1;
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer
module tb_multicycle_sequencer;

  typedef struct {
    logic [2:0] st;
    logic       done;
    logic       ill;
  } exp_t;

`ifdef MULTICYCLE_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic [2:0]  state;
  logic        instr_done, halted, illegal_op;
  logic [15:0] cycle_count, instr_count;

  int checks = 0;
  int failures = 0;
  exp_t q[$];

  multicycle_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .state       (state),
    .instr_done  (instr_done),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check_eq("state", 32'(state), 32'(e.st));
      check_eq("instr_done", 32'(instr_done), 32'(e.done));
      check_eq("halted", 32'(halted), 32'(e.st == 3'd5));
      check_eq("illegal_op", 32'(illegal_op), 32'(e.ill));
    end
  end

  task automatic cyc(input logic [2:0] es, input logic ed, input logic eill,
                     input logic mr, input logic [5:0] op, input logic [7:0] p);
    exp_t e;
    mem_ready = mr;
    opcode    = op;
    pc        = p;
    e.st = es; e.done = ed; e.ill = eill;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_cycle_count", 32'(cycle_count), 32'd0);
    check_eq("rst_instr_count", 32'(instr_count), 32'd0);
  endtask

  task automatic rtype(input logic [7:0] p_end);
    cyc(3'd0, 1'b0, 1'b0, 1'b1, 6'b000000, 8'd3);
    cyc(3'd1, 1'b0, 1'b0, 1'b0, 6'b000000, 8'd3);
    cyc(3'd2, 1'b0, 1'b0, 1'b0, 6'b000000, 8'd3);
    cyc(3'd4, 1'b1, 1'b0, 1'b0, 6'b000000, p_end);
  endtask

  initial begin
    rst = 1'b1; pc = '0; opcode = '0; mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // IF stall, then RTYPE with pc one below the end boundary
    cyc(3'd0, 1'b0, 1'b0, 1'b0, 6'b000000, 8'd3);
    rtype(8'd3);
    rtype(8'd10);

    // LW with two-cycle MEM stall; opcode changes after ID must not matter
    cyc(3'd0, 1'b0, 1'b0, 1'b1, 6'b100011, 8'd3);
    cyc(3'd1, 1'b0, 1'b0, 1'b0, 6'b100011, 8'd3);
    cyc(3'd2, 1'b0, 1'b0, 1'b1, 6'b000100, 8'd3);
    cyc(3'd3, 1'b0, 1'b0, 1'b0, 6'b101011, 8'd3);
    cyc(3'd3, 1'b0, 1'b0, 1'b0, 6'b100011, 8'd3);
    cyc(3'd3, 1'b0, 1'b0, 1'b1, 6'b100011, 8'd3);
    cyc(3'd4, 1'b1, 1'b0, 1'b0, 6'b100011, 8'd3);

    // SW, BEQ, BNE, J at pc=5
    cyc(3'd0, 1'b0, 1'b0, 1'b1, 6'b101011, 8'd5);
    cyc(3'd1, 1'b0, 1'b0, 1'b1, 6'b101011, 8'd5);
    cyc(3'd2, 1'b0, 1'b0, 1'b1, 6'b101011, 8'd5);
    cyc(3'd3, 1'b1, 1'b0, 1'b1, 6'b101011, 8'd5);
    cyc(3'd0, 1'b0, 1'b0, 1'b1, 6'b000100, 8'd5);
    cyc(3'd1, 1'b0, 1'b0, 1'b1, 6'b000100, 8'd5);
    cyc(3'd2, 1'b1, 1'b0, 1'b1, 6'b000100, 8'd5);
    cyc(3'd0, 1'b0, 1'b0, 1'b1, 6'b000101, 8'd5);
    cyc(3'd1, 1'b0, 1'b0, 1'b1, 6'b000101, 8'd5);
    cyc(3'd2, 1'b1, 1'b0, 1'b1, 6'b000101, 8'd5);
    cyc(3'd0, 1'b0, 1'b0, 1'b1, 6'b000010, 8'd5);
    cyc(3'd1, 1'b1, 1'b0, 1'b1, 6'b000010, 8'd5);

    // RTYPE ending at pc=11 halts; OUTPUT absorbs random inputs
    rtype(8'd11);
    for (int i = 0; i < 20; i++)
      cyc(3'd5, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 6'($urandom), 8'($urandom));

    // illegal opcode
    do_reset();
    cyc(3'd0, 1'b0, 1'b0, 1'b1, 6'b111111, 8'd3);
    cyc(3'd1, 1'b0, 1'b0, 1'b1, 6'b111111, 8'd3);
    for (int i = 0; i < 4; i++)
      cyc(3'd5, 1'b0, 1'b1, 1'b1, 6'b000000, 8'd3);

    // reset during MEM stall
    do_reset();
    cyc(3'd0, 1'b0, 1'b0, 1'b1, 6'b100011, 8'd3);
    cyc(3'd1, 1'b0, 1'b0, 1'b0, 6'b100011, 8'd3);
    cyc(3'd2, 1'b0, 1'b0, 1'b0, 6'b100011, 8'd3);
    cyc(3'd3, 1'b0, 1'b0, 1'b0, 6'b100011, 8'd3);
    do_reset();
    cyc(3'd0, 1'b0, 1'b0, 1'b0, 6'b100011, 8'd3);

    // counters: four RTYPE instructions, last one ends the program
    do_reset();
    rtype(8'd3);
    rtype(8'd3);
    rtype(8'd3);
    rtype(8'd11);
    check_eq("instr_count", 32'(instr_count), PERF ? 32'd4 : 32'd0);
    check_eq("cycle_count", 32'(cycle_count), PERF ? 32'd16 : 32'd0);
    for (int i = 0; i < 5; i++)
      cyc(3'd5, 1'b0, 1'b0, 1'b1, 6'b000000, 8'd3);
    check_eq("instr_count_frozen", 32'(instr_count), PERF ? 32'd4 : 32'd0);
    check_eq("cycle_count_frozen", 32'(cycle_count), PERF ? 32'd16 : 32'd0);

    check_eq("sb_drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
